issue_ctrl: RTL
===============

# issue_ctrl

Dual-issue scheduler between the instruction queue output and the REG/EX1 stage. Each cycle it takes the decoded pair from the queue and issues one or both slots. It splits pairs that cannot co-issue and serialises privileged instructions against an empty backend. Issue outputs are registered, forming the REG-stage input register.

## Interface
- PAYLOAD_W, 128: opaque per-slot payload width (pc, inst, imm, uop, badv, …), passed through unchanged.
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low; clock aclk
- flush  in  1  synchronous pipeline flush
- iq_valid  in  1  queue presents a pair
- iq_ready  out  1  pair consumed this cycle (combinational)
- pair_valid  in  2  per-slot valid; bit1 implies bit0
- payload0/payload1  in  PAYLOAD_W  per-slot payload
- rd0/rj0/rk0, rd1/rj1/rk1  in  5 each  register indices
- is_alu  in  2  per-slot: slot is a plain ALU op
- is_priv  in  2  per-slot: privileged (CSR/TLB/ertn/idle)
- is_trap  in  2  per-slot: syscall, break or nonzero exception code
- is_branch  in  2  per-slot branch flag
- ex_allowin  in  1  REG/EX1 accepts the issue register this cycle
- backend_empty  in  1  no instruction in EX1…WB
- iss_valid  out  2  issued slots; slot1 only with slot0
- iss_payload0/1  out  PAYLOAD_W  issued payloads
- iss_rd0/rj0/rk0, iss_rd1/rj1/rk1  out  5 each  issued indices
- iss_priv  out  1  slot0 is privileged
- perf_dual  out  32  count of dual issues

## Operation
- dual_ok = pair_valid==2'b11 & is_alu[1] & ~is_priv[0] & ~is_priv[1] & ~is_trap[0] & ~is_trap[1] & ~is_branch[0] & ~(rd0!=0 & (rd0==rj1 | rd0==rk1)).
- A privileged instruction is "clear to issue" when backend_empty & iss_valid==0.
- One-entry hold register stores a split-off slot1, including payload, indices and flags.
- RUN: issue requires iq_valid & ex_allowin.
  - Slot0 privileged and not clear: issue nothing, iq_ready=0, go DRAIN.
  - Else if dual_ok: issue both, iq_ready=1, perf_dual++.
  - Else: issue slot0 alone, iq_ready=1, and latch slot1 into hold if pair_valid[1].
  - Next state after issuing alone: POST if slot0 privileged, else SPLIT if hold was filled, else RUN.
- SPLIT: iq_ready=0. When ex_allowin:
  - If the held instruction is privileged and not clear, wait.
  - Otherwise issue it as slot0 alone, clear hold, and go POST if privileged, else RUN.
- DRAIN: iq_ready=0 and no issue; go RUN when backend_empty & iss_valid==0.
- POST: iq_ready=0 and no issue; when clear, go SPLIT if hold valid, else RUN.
- ex_allowin=0: issue register and state hold; iq_ready=0.
- ex_allowin=1 with nothing issued: iss_valid<=0 (bubble).
- flush has highest priority and overrides any issue in that cycle:
  - iss_valid<=0, hold cleared, state<=RUN, iq_ready=0.
  - perf_dual is kept.
- perf_dual wraps modulo 2^32.

## Timing
- Reset (aresetn=0 at an aclk edge) takes effect at that edge:
  - iss_valid=0, all iss_* payloads and indices 0, iss_priv=0.
  - state RUN, hold empty, perf_dual=0.
  - iq_ready=0 while aresetn=0.
- Latency: pair accepted at edge N appears on iss_* after edge N; iss_valid is high in cycle N+1.
- A split pair occupies two consecutive issue cycles when ex_allowin stays high.
- iq_ready depends combinationally on iq_valid, pair fields, ex_allowin, backend_empty and state; it never depends on flush-registered state of the same cycle.
- Simultaneous flush and iq_valid/ex_allowin: flush wins and nothing is consumed.
- A single-slot pair (pair_valid=2'b01) never enters SPLIT.

## Test plan
- Independent ALU pair (rd0=3, rj1=4, rk1=5), ex_allowin=1 -> next cycle iss_valid=2'b11, iq_ready=1, perf_dual=1.
- RAW pair (rd0=3, rj1=3) -> iss_valid=2'b01 with slot0, next cycle iss_valid=2'b01 carrying the old slot1 payload, iq_ready low in the SPLIT cycle.
- Slot0 is_priv with backend_empty=0 for 3 cycles -> no issue, iq_ready=0; backend_empty rises -> priv issues alone with iss_priv=1, then no issue until backend_empty again.
- rd0=0 with rj1=0 -> dual issue allowed; branch in slot0 -> split.
- Flush while in SPLIT with hold valid -> next cycle iss_valid=0, hold empty; new pair issues normally.
- ex_allowin=0 for 2 cycles after an issue -> iss_* stable and iq_ready=0; reset mid-SPLIT -> all outputs 0, state RUN.

Source files
------------

// File: rtl/issue_ctrl_if.sv
// Queue-to-issue handshake bundle for issue_ctrl: decoded pair in, REG-stage issue register out.
// master drives the queue/backend side; slave is the scheduler.
interface issue_ctrl_if #(
  parameter int unsigned PAYLOAD_W = 128
);
  logic                 flush;
  logic                 iq_valid;
  logic                 iq_ready;
  logic [1:0]           pair_valid;
  logic [PAYLOAD_W-1:0] payload0;
  logic [PAYLOAD_W-1:0] payload1;
  logic [4:0]           rd0, rj0, rk0;
  logic [4:0]           rd1, rj1, rk1;
  logic [1:0]           is_alu;
  logic [1:0]           is_priv;
  logic [1:0]           is_trap;
  logic [1:0]           is_branch;
  logic                 ex_allowin;
  logic                 backend_empty;
  logic [1:0]           iss_valid;
  logic [PAYLOAD_W-1:0] iss_payload0;
  logic [PAYLOAD_W-1:0] iss_payload1;
  logic [4:0]           iss_rd0, iss_rj0, iss_rk0;
  logic [4:0]           iss_rd1, iss_rj1, iss_rk1;
  logic                 iss_priv;
  logic [31:0]          perf_dual;

  modport master (
    output flush, iq_valid, pair_valid, payload0, payload1, rd0, rj0, rk0, rd1, rj1, rk1,
           is_alu, is_priv, is_trap, is_branch, ex_allowin, backend_empty,
    input  iq_ready, iss_valid, iss_payload0, iss_payload1, iss_rd0, iss_rj0, iss_rk0,
           iss_rd1, iss_rj1, iss_rk1, iss_priv, perf_dual
  );

  modport slave (
    input  flush, iq_valid, pair_valid, payload0, payload1, rd0, rj0, rk0, rd1, rj1, rk1,
           is_alu, is_priv, is_trap, is_branch, ex_allowin, backend_empty,
    output iq_ready, iss_valid, iss_payload0, iss_payload1, iss_rd0, iss_rj0, iss_rk0,
           iss_rd1, iss_rj1, iss_rk1, iss_priv, perf_dual
  );
endinterface

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: splits pairs that cannot co-issue and serialises privileged
// instructions against an empty backend. Issue outputs form the REG-stage input register.
module issue_ctrl #(
  parameter int unsigned PAYLOAD_W = 128
) (
  input logic       aclk,
  input logic       aresetn,
  issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StSplit, StDrain, StPost} state_e;

  state_e               state_q, state_d;
  logic                 hold_valid_q, hold_priv_q;
  logic [PAYLOAD_W-1:0] hold_payload_q;
  logic [4:0]           hold_rd_q, hold_rj_q, hold_rk_q;

  logic [1:0]           iss_valid_q;
  logic [PAYLOAD_W-1:0] iss_payload0_q, iss_payload1_q;
  logic [4:0]           iss_rd0_q, iss_rj0_q, iss_rk0_q, iss_rd1_q, iss_rj1_q, iss_rk1_q;
  logic                 iss_priv_q;
  logic [31:0]          perf_dual_q;

  logic clear, raw, dual_ok;
  logic take_q, take_hold, bubble, hold_load, hold_clr, iq_ready_c;
  logic unused_flags;

  assign unused_flags = ^{bus.is_alu[0], bus.is_branch[1]};

  // A privileged op may only go once nothing is in flight, including the issue register.
  assign clear   = bus.backend_empty & (iss_valid_q == 2'b00);
  assign raw     = (bus.rd0 != 5'd0) & ((bus.rd0 == bus.rj1) | (bus.rd0 == bus.rk1));
  assign dual_ok = (bus.pair_valid == 2'b11) & bus.is_alu[1] & ~bus.is_priv[0] &
                   ~bus.is_priv[1] & ~bus.is_trap[0] & ~bus.is_trap[1] & ~bus.is_branch[0] &
                   ~raw;

  always_comb begin
    state_d    = state_q;
    take_q     = 1'b0;
    take_hold  = 1'b0;
    bubble     = 1'b0;
    hold_load  = 1'b0;
    hold_clr   = 1'b0;
    iq_ready_c = 1'b0;
    if (!bus.flush && bus.ex_allowin) begin
      unique case (state_q)
        StRun: begin
          if (!bus.iq_valid) begin
            bubble = 1'b1;
          end else if (bus.is_priv[0] && !clear) begin
            bubble  = 1'b1;
            state_d = StDrain;
          end else begin
            take_q     = 1'b1;
            iq_ready_c = 1'b1;
            if (!dual_ok) begin
              hold_load = bus.pair_valid[1];
              if (bus.is_priv[0])          state_d = StPost;
              else if (bus.pair_valid[1])  state_d = StSplit;
            end
          end
        end
        StSplit: begin
          if (hold_priv_q && !clear) begin
            bubble = 1'b1;
          end else begin
            take_hold = 1'b1;
            hold_clr  = 1'b1;
            state_d   = hold_priv_q ? StPost : StRun;
          end
        end
        StDrain: begin
          bubble = 1'b1;
          if (clear) state_d = StRun;
        end
        StPost: begin
          bubble = 1'b1;
          if (clear) state_d = hold_valid_q ? StSplit : StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= StRun;
      hold_valid_q   <= 1'b0;
      hold_priv_q    <= 1'b0;
      hold_payload_q <= '0;
      hold_rd_q      <= '0;
      hold_rj_q      <= '0;
      hold_rk_q      <= '0;
      iss_valid_q    <= '0;
      iss_payload0_q <= '0;
      iss_payload1_q <= '0;
      iss_rd0_q      <= '0;
      iss_rj0_q      <= '0;
      iss_rk0_q      <= '0;
      iss_rd1_q      <= '0;
      iss_rj1_q      <= '0;
      iss_rk1_q      <= '0;
      iss_priv_q     <= 1'b0;
      perf_dual_q    <= '0;
    end else if (bus.flush) begin
      state_q      <= StRun;
      hold_valid_q <= 1'b0;
      iss_valid_q  <= '0;
      iss_priv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_q) begin
        iss_valid_q    <= dual_ok ? 2'b11 : 2'b01;
        iss_payload0_q <= bus.payload0;
        iss_payload1_q <= bus.payload1;
        iss_rd0_q      <= bus.rd0;
        iss_rj0_q      <= bus.rj0;
        iss_rk0_q      <= bus.rk0;
        iss_rd1_q      <= bus.rd1;
        iss_rj1_q      <= bus.rj1;
        iss_rk1_q      <= bus.rk1;
        iss_priv_q     <= bus.is_priv[0];
        if (dual_ok) perf_dual_q <= perf_dual_q + 32'd1;
      end else if (take_hold) begin
        iss_valid_q    <= 2'b01;
        iss_payload0_q <= hold_payload_q;
        iss_rd0_q      <= hold_rd_q;
        iss_rj0_q      <= hold_rj_q;
        iss_rk0_q      <= hold_rk_q;
        iss_priv_q     <= hold_priv_q;
      end else if (bubble) begin
        iss_valid_q <= '0;
        iss_priv_q  <= 1'b0;
      end
      if (hold_load) begin
        hold_valid_q   <= 1'b1;
        hold_priv_q    <= bus.is_priv[1];
        hold_payload_q <= bus.payload1;
        hold_rd_q      <= bus.rd1;
        hold_rj_q      <= bus.rj1;
        hold_rk_q      <= bus.rk1;
      end else if (hold_clr) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  assign bus.iq_ready     = iq_ready_c & aresetn;
  assign bus.iss_valid    = iss_valid_q;
  assign bus.iss_payload0 = iss_payload0_q;
  assign bus.iss_payload1 = iss_payload1_q;
  assign bus.iss_rd0      = iss_rd0_q;
  assign bus.iss_rj0      = iss_rj0_q;
  assign bus.iss_rk0      = iss_rk0_q;
  assign bus.iss_rd1      = iss_rd1_q;
  assign bus.iss_rj1      = iss_rj1_q;
  assign bus.iss_rk1      = iss_rk1_q;
  assign bus.iss_priv     = iss_priv_q;
  assign bus.perf_dual    = perf_dual_q;

endmodule
